// File: rtl/chan_err_inj.sv
// Channel model / error injector: registers each accepted 2-bit encoded word and flips bits
// under a periodic or LFSR-driven policy with a guard spacing. Optional: ERR_INJ_DOUBLE_EN.
module chan_err_inj #(
  parameter int          LFSR_W = 16,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          CT_W   = 16,
  parameter int          GUARD  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_i,
  input  logic [1:0]      enc_i,
  input  logic [1:0]      err_mode_i,
  input  logic [7:0]      period_i,
  input  logic [7:0]      thresh_i,
  output logic [1:0]      chan_o,
  output logic            valid_o,
  output logic [1:0]      err_inj,
  output logic [CT_W-1:0] word_ct,
  output logic [CT_W-1:0] error_counter
);

  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD + 1);
  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_W'(1) : LFSR_W'(SEED);
  localparam logic [GW-1:0]     GUARD_LD = GW'(GUARD);

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_HOLDOFF} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     guard, guard_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt;
  logic [7:0]        phase;
  logic              alt;
  logic [1:0]        mask;
  logic              mode_on, per_hit, rnd_hit, inject;
  logic [1:0]        chan_p1, inj_p1;
  logic              vld_p1;

  function automatic logic [CT_W-1:0] sat_add(input logic [CT_W-1:0] a, input logic [1:0] b);
    logic [CT_W:0] s;
    s = {1'b0, a} + (CT_W+1)'(b);
    return s[CT_W] ? '1 : s[CT_W-1:0];
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

  assign mode_on  = (err_mode_i == 2'b01) || (err_mode_i == 2'b10);
  assign per_hit  = (err_mode_i == 2'b01) && (period_i != 8'd0) && (phase == period_i - 8'd1);
  assign rnd_hit  = (err_mode_i == 2'b10) && (lfsr[7:0] < thresh_i);
  assign inject   = enable_i && (state == S_ARMED) && (per_hit || rnd_hit);
  assign lfsr_nxt = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);

  always_comb begin
    mask = 2'b00;
    if (inject) begin
      if (per_hit) begin
        mask = alt ? 2'b10 : 2'b01;
      end else begin
        mask = lfsr[8] ? 2'b10 : 2'b01;
`ifdef ERR_INJ_DOUBLE_EN
        if (lfsr[9]) mask = 2'b11;
`endif
      end
    end
  end

  // Guard counter only moves on accepted words; an off/reserved mode aborts holdoff at once.
  always_comb begin
    state_nxt = state;
    guard_nxt = guard;
    if (inject) begin
      guard_nxt = GUARD_LD;
    end else if (enable_i && (state == S_HOLDOFF) && (guard != '0)) begin
      guard_nxt = guard - 1'b1;
    end
    if (!mode_on) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:     state_nxt = S_ARMED;
        S_ARMED:   state_nxt = (inject && (GUARD != 0)) ? S_HOLDOFF : S_ARMED;
        S_HOLDOFF: state_nxt = (enable_i && (guard <= GW'(1))) ? S_ARMED : S_HOLDOFF;
        default:   state_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
      guard <= '0;
      phase <= 8'd0;
      alt   <= 1'b0;
      lfsr  <= SEED_EFF;
    end else begin
      state <= state_nxt;
      guard <= guard_nxt;
      if (err_mode_i != 2'b01) begin
        phase <= 8'd0;
      end else if (enable_i) begin
        phase <= per_hit ? 8'd0 : phase + 8'd1;
      end
      if (enable_i) begin
        lfsr <= lfsr_nxt;
        if (inject && per_hit) alt <= ~alt;
      end
    end
  end

  // Stage p1: channel output register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_p1       <= 2'b00;
      inj_p1        <= 2'b00;
      vld_p1        <= 1'b0;
      word_ct       <= '0;
      error_counter <= '0;
    end else begin
      vld_p1 <= enable_i;
      if (enable_i) begin
        chan_p1       <= enc_i ^ mask;
        inj_p1        <= mask;
        word_ct       <= sat_add(word_ct, 2'd1);
        error_counter <= sat_add(error_counter, popcount2(mask));
      end
    end
  end

  assign chan_o  = chan_p1;
  assign err_inj = inj_p1;
  assign valid_o = vld_p1;

endmodule

// File: tb/tb_chan_err_inj.sv
// Scoreboard bench for chan_err_inj: a behavioural channel model predicts each registered
// word; a second instance (CT_W=4, GUARD=0) exercises counter saturation.
module tb_chan_err_inj;
  localparam int GUARD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [1:0]  enc_i, err_mode_i;
  logic [7:0]  period_i, thresh_i;
  logic [1:0]  chan_o, err_inj;
  logic        valid_o;
  logic [15:0] word_ct, error_counter;
  logic [1:0]  s_chan, s_inj;
  logic        s_vld;
  logic [3:0]  s_word_ct, s_error_counter;

  chan_err_inj #(.CT_W(16), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .enc_i(enc_i), .err_mode_i(err_mode_i),
    .period_i(period_i), .thresh_i(thresh_i), .chan_o(chan_o), .valid_o(valid_o),
    .err_inj(err_inj), .word_ct(word_ct), .error_counter(error_counter));

  chan_err_inj #(.CT_W(4), .GUARD(0)) dut_sat (
    .clk(clk), .rst(rst), .enable_i(enable_i), .enc_i(enc_i), .err_mode_i(err_mode_i),
    .period_i(period_i), .thresh_i(thresh_i), .chan_o(s_chan), .valid_o(s_vld),
    .err_inj(s_inj), .word_ct(s_word_ct), .error_counter(s_error_counter));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic [1:0] i;
  } exp_t;
  exp_t sb[$];

  // Reference channel model state
  int         m_state;  // 0 off, 1 armed, 2 holdoff
  int         m_guard;
  logic [15:0] m_lfsr;
  logic [7:0] m_phase;
  logic       m_alt;
  logic [1:0] m_chan, m_inj;
  int         m_wc, m_ec;
  int         s_ec;
  bit         sat_track;
  int         widx, last_inj, seg_inj, seg_first;

  function automatic int popc(input logic [1:0] m);
    return int'(m[0]) + int'(m[1]);
  endfunction

  function automatic int clamp(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_guard = 0; m_lfsr = 16'hACE1; m_phase = 8'd0; m_alt = 1'b0;
    m_chan = 2'b00; m_inj = 2'b00; m_wc = 0; m_ec = 0; s_ec = 0;
    widx = 0; last_inj = -1;
    sb.delete();
  endtask

  task automatic model_step();
    logic acc, on, ph, rh, inj;
    logic [1:0] mask, smask;
    logic [15:0] nl;
    exp_t e;
    int ns;
    acc = enable_i;
    on  = (err_mode_i == 2'b01) || (err_mode_i == 2'b10);
    ph  = (err_mode_i == 2'b01) && (period_i != 8'd0) && (m_phase == period_i - 8'd1);
    rh  = (err_mode_i == 2'b10) && (m_lfsr[7:0] < thresh_i);
    inj = acc && (m_state == 1) && (ph || rh);
    mask = 2'b00;
    smask = m_lfsr[8] ? 2'b10 : 2'b01;
`ifdef ERR_INJ_DOUBLE_EN
    if (m_lfsr[9]) smask = 2'b11;
`endif
    if (inj) begin
      if (ph) begin
        mask = m_alt ? 2'b10 : 2'b01;
      end else begin
        mask = smask;
      end
    end
    if (sat_track && acc && rh) s_ec += popc(smask);
    if (!on) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 1) ns = (inj && GUARD > 0) ? 2 : 1;
    else ns = (acc && m_guard <= 1) ? 1 : 2;
    if (inj) m_guard = GUARD;
    else if (acc && m_state == 2 && m_guard > 0) m_guard--;
    m_state = ns;
    if (err_mode_i != 2'b01) m_phase = 8'd0;
    else if (acc) m_phase = ph ? 8'd0 : m_phase + 8'd1;
    if (acc) begin
      m_chan = enc_i ^ mask;
      m_inj  = mask;
      m_wc++;
      m_ec  += popc(mask);
      nl = m_lfsr >> 1;
      if (m_lfsr[0]) nl ^= 16'hB400;
      m_lfsr = nl;
      if (inj && ph) m_alt = ~m_alt;
    end
    e.v = acc; e.c = m_chan; e.i = m_inj;
    sb.push_back(e);
  endtask

  // One clock: drive, predict, then compare the registered result 1 time unit after the edge.
  task automatic word(input logic en, input logic [1:0] enc);
    exp_t e;
    enable_i = en;
    enc_i    = enc;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("valid_o", valid_o, e.v);
    check_eq("chan_o", chan_o, e.c);
    check_eq("err_inj", err_inj, e.i);
    if (en) begin
      if (err_inj != 2'b00) begin
        if (last_inj >= 0) check_eq("guard_spacing", (widx - last_inj) >= GUARD + 1, 1);
        last_inj = widx;
        if (seg_first < 0) seg_first = seg_inj;
      end
      widx++;
      seg_inj++;
    end
  endtask

  task automatic set_mode(input logic [1:0] m, input logic [7:0] p, input logic [7:0] t);
    err_mode_i = m; period_i = p; thresh_i = t;
    seg_inj = 0; seg_first = -1;
    word(1'b0, 2'b00);
    seg_inj = 0;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_word_ct"}, word_ct, clamp(m_wc, 65535));
    check_eq({tag, "_error_counter"}, error_counter, clamp(m_ec, 65535));
  endtask

  // Asserted between edges; outputs must clear before any clock edge arrives.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_chan_o", chan_o, 0);
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_err_inj", err_inj, 0);
    check_eq("rst_word_ct", word_ct, 0);
    check_eq("rst_error_counter", error_counter, 0);
    check_eq("rst_lfsr", dut.lfsr, 16'hACE1);
    #28;
    enable_i = 1'b0;
    err_mode_i = 2'b00;
    rst = 1'b0;
    model_reset();
  endtask

  logic [1:0] enc_rec[50];
  logic [1:0] inj_rec[50];

  initial begin
    rst = 1'b1; enable_i = 1'b0; enc_i = 2'b00; err_mode_i = 2'b00;
    period_i = 8'd0; thresh_i = 8'd0; sat_track = 1'b0;
    seg_inj = 0; seg_first = -1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Pass-through: mode off
    set_mode(2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 300; i++) word(1'b1, 2'($urandom));
    check_eq("off_word_ct", word_ct, 300);
    check_eq("off_error_counter", error_counter, 0);

    // Periodic, every 8 words
    set_mode(2'b01, 8'd8, 8'd0);
    for (int i = 0; i < 64; i++) word(1'b1, 2'($urandom));
    check_eq("per8_first", seg_first, 7);
    check_eq("per8_error_counter", error_counter, 8);
    check_counters("per8");

    // Periodic, every 3 words: injections due in holdoff are skipped
    set_mode(2'b01, 8'd3, 8'd0);
    for (int i = 0; i < 30; i++) word(1'b1, 2'($urandom));
    check_counters("per3");

    // Random, always-below threshold, with idle gaps
    set_mode(2'b10, 8'd0, 8'hFF);
    for (int i = 0; i < 100; i++) begin
      word(1'b1, 2'($urandom));
      if (i % 17 == 5) word(1'b0, 2'($urandom));
    end
    check_counters("rndff");

    // Random, zero threshold: no injections
    set_mode(2'b10, 8'd0, 8'd0);
    for (int i = 0; i < 30; i++) word(1'b1, 2'($urandom));
    check_eq("rnd0_injections", error_counter, m_ec);
    check_counters("rnd0");

    // Reset mid-stream and replay: identical error pattern
    do_reset();
    set_mode(2'b10, 8'd0, 8'h50);
    for (int i = 0; i < 50; i++) begin
      enc_rec[i] = 2'($urandom);
      word(1'b1, enc_rec[i]);
      inj_rec[i] = err_inj;
    end
    enable_i = 1'b1;
    do_reset();
    set_mode(2'b10, 8'd0, 8'h50);
    for (int i = 0; i < 50; i++) begin
      word(1'b1, enc_rec[i]);
      check_eq("replay_err_inj", err_inj, inj_rec[i]);
    end
    check_counters("replay");

    // Saturation on the narrow-counter instance
    do_reset();
    sat_track = 1'b1;
    set_mode(2'b10, 8'd0, 8'hFF);
    for (int i = 0; i < 20; i++) word(1'b1, 2'($urandom));
    check_eq("sat_word_ct", s_word_ct, 15);
    check_eq("sat_error_counter", s_error_counter, clamp(s_ec, 15));
    check_counters("sat_main");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_err_inj.md
# chan_err_inj

Channel model and error injector between the convolutional encoder and the Viterbi decoder in the tx/rx loopback. Each accepted 2-bit encoded word passes through a one-cycle register, where bits are flipped under a periodic or pseudo-random policy. The block enforces a minimum guard spacing between injections so the decoder's correction capability is exercised without overwhelming it. It keeps saturating word and error counters, which the bench reads hierarchically.

## Interface
Parameters:
- LFSR_W, 16, width of the error-pattern LFSR (fixed polynomial is 16-bit; only 16 supported)
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001
- CT_W, 16, width of word_ct and error_counter
- GUARD, 4, number of accepted words after an injection during which no injection is allowed

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- enable_i  in  1  encoder word valid; a word is accepted on a clk edge where this is high
- enc_i  in  2  encoded word from the convolutional encoder
- err_mode_i  in  2  00 off, 01 periodic, 10 random, 11 reserved (treated as off)
- period_i  in  8  periodic mode: inject once every period_i accepted words; 0 means never
- thresh_i  in  8  random mode: inject when lfsr[7:0] < thresh_i; 0 means never
- chan_o  out  2  enc_i XOR err_inj, registered
- valid_o  out  1  registered copy of enable_i
- err_inj  out  2  flip mask applied to the word currently on chan_o
- word_ct  out  CT_W  accepted-word count, saturating
- error_counter  out  CT_W  total flipped bits, saturating

## Operation
FSM states:
- OFF:
  - Entered when err_mode_i is 00 or 11.
  - Mask is always 00.
  - Goes to ARMED on the first edge where the mode is 01 or 10.
- ARMED:
  - On an accepted word, the injection condition is evaluated.
  - If the condition holds: the mask is nonzero, the guard counter is loaded with GUARD, and the FSM goes to HOLDOFF.
- HOLDOFF:
  - Each accepted word decrements the guard counter; mask is 00.
  - At 0 (after GUARD accepted words) the FSM returns to ARMED.
  - With GUARD=0, the FSM stays in ARMED.

Mode and datapath rules:
- In any state, an off or reserved mode sends the FSM to OFF on the next edge, aborting HOLDOFF.
- Periodic mode:
  - An 8-bit phase counter increments on each accepted word while the mode is 01.
  - The condition holds when phase == period_i-1; phase then wraps to 0.
  - The phase counter keeps running in HOLDOFF, so a due injection is skipped, not deferred.
  - The flipped bit alternates 01, 10, 01, ... starting with 01 after reset.
  - The phase counter clears whenever the mode is not 01.
- Random mode:
  - Condition: lfsr[7:0] < thresh_i (unsigned).
  - Mask is 01 when lfsr[8]=0 and 10 when lfsr[8]=1.
- LFSR:
  - Galois form, polynomial x^16+x^14+x^13+x^11+1.
  - Advances once per accepted word in every mode, so patterns are repeatable from reset.
- word_ct increments by 1 per accepted word and holds at all-ones.
- error_counter adds the popcount of the applied mask and holds at all-ones; the add is CT_W+1 bits wide and clamped.
- With enable_i low: chan_o, err_inj, the counters, the LFSR, the phase counter and the guard counter all hold; valid_o goes to 0.

## Timing
- Latency from enc_i/enable_i to chan_o/valid_o/err_inj is exactly 1 cycle.
- Counters update on the same edge as chan_o.
- Reset values:
  - chan_o=00, valid_o=0, err_inj=00, word_ct=0, error_counter=0
  - FSM=OFF, LFSR=SEED, phase=0, guard=0, alternation flag selects 01
- Reset asserted mid-stream clears all state immediately, with no edge required. The first accepted word after deassertion sees the FSM in OFF, so it is never corrupted.
- Changes to err_mode_i, period_i and thresh_i are sampled on each edge. A mode change takes effect for the word accepted on the edge after the change.

## Configuration
- ERR_INJ_DOUBLE_EN defined:
  - Random mode applies mask 11 when lfsr[9]=1 and the condition holds; otherwise 01 or 10 as above.
  - error_counter then increments by 2 for such a word.
- ERR_INJ_DOUBLE_EN undefined:
  - Mask never equals 11.
  - lfsr[9] is unused.

## Test plan
- Mode 00, 300 words with enable_i=1 -> chan_o equals enc_i delayed 1 cycle; err_inj=00 throughout; word_ct=300; error_counter=0.
- Mode 01, period_i=8, GUARD=4, 64 words -> injections on words 7, 15, 23, ...; masks alternate 01, 10; error_counter=8.
- Mode 01, period_i=3, GUARD=4 -> every injection due within holdoff is skipped; no two injections are closer than 5 words.
- Mode 10, thresh_i=8'hFF, 100 words -> an injection occurs whenever ARMED, spaced exactly GUARD+1 words apart; error_counter=20 with GUARD=4 and the macro off. With thresh_i=0 there are no injections.
- Pulse rst for 30 time units mid-stream after 50 words -> all outputs read 0 immediately; LFSR is back at SEED; the repeated random run reproduces an identical err_inj sequence.
- Preload word_ct near all-ones (CT_W=4, 20 words) -> word_ct holds at 15; error_counter also saturates at 15 under thresh_i=8'hFF.
